// File: rtl/id_pkg.sv
// Shared decode constants, queue-entry layout and output-register type for the
// instruction-decode stage and its operand-use decoder.
package id_pkg;

  localparam int XLEN    = 32;
  localparam int ENTRY_W = XLEN + XLEN + 1;

  // Queue entry layout: {pc, inst, in_delay}, delay flag in bit 0.
  localparam int ENT_DLY_OFF  = 0;
  localparam int ENT_INST_OFF = 1;
  localparam int ENT_PC_OFF   = 1 + XLEN;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  // SPECIAL function codes (inst[5:0])
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            in_delay;
  } ex_reg_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/id_stage_q_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Both sides: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge, ready may depend on state only.
interface id_stage_q_if;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_in_delay;

  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic        ex_in_delay;

  modport slave (
    input  if_valid, if_pc, if_inst, if_in_delay,
    output if_ready,
    output ex_valid, ex_pc, ex_inst, ex_src1, ex_src2, ex_in_delay,
    input  ex_ready
  );

  modport master (
    output if_valid, if_pc, if_inst, if_in_delay,
    input  if_ready,
    input  ex_valid, ex_pc, ex_inst, ex_src1, ex_src2, ex_in_delay,
    output ex_ready
  );

endinterface

// File: rtl/id_regsel.sv
// Operand-use decode: tells whether an instruction reads rs (rreg1) and rt (rreg2).
// Only opcode and funct matter; the register fields are ignored here.
module id_regsel
  import id_pkg::*;
(
  input  logic [31:0] inst,
  output logic        rreg1,
  output logic        rreg2
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = inst[31:26];
  assign funct         = inst[5:0];
  assign unused_fields = ^inst[25:6];

  always_comb begin
    rreg1 = 1'b0;
    rreg2 = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA:                 rreg2 = 1'b1;
          F_JR, F_JALR, F_MTHI, F_MTLO:        rreg1 = 1'b1;
          F_MFHI, F_MFLO, F_SYSCALL, F_BREAK: begin
            rreg1 = 1'b0;
            rreg2 = 1'b0;
          end
          default: begin
            rreg1 = 1'b1;
            rreg2 = 1'b1;
          end
        endcase
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ:             rreg1 = 1'b1;
      OP_BEQ, OP_BNE: begin
        rreg1 = 1'b1;
        rreg2 = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI:                rreg1 = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:     rreg1 = 1'b1;
      // Unaligned loads merge into the old rt value, so they read it too.
      OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        rreg1 = 1'b1;
        rreg2 = 1'b1;
      end
      default: begin
        rreg1 = 1'b0;
        rreg2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_q.sv
// Decode stage: small instruction queue, operand read with forwarding and
// load-use stall, and a registered valid/ready output toward execute.
module id_stage_q
  import id_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int NFWD       = 2,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  id_stage_q_if.slave            bus,
  input  logic                   flush,
  output logic [4:0]             ra1,
  output logic [4:0]             ra2,
  input  logic [31:0]            rd1,
  input  logic [31:0]            rd2,
  input  logic [NFWD-1:0]        fwd_wreg,
  input  logic [NFWD-1:0]        fwd_mreg,
  input  logic [5*NFWD-1:0]      fwd_wa,
  input  logic [32*NFWD-1:0]     fwd_wd,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  ex_reg_t            ex_q, ex_d;
  logic               ex_valid_q, ex_valid_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic               empty;
  logic               push;
  logic               pop;
  logic               stall;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] new_entry;
  logic [31:0]        in_inst;
  logic [31:0]        head_inst;
  logic               rreg1_raw, rreg2_raw;
  logic               rreg1, rreg2;
  logic [31:0]        src1, src2;
  logic               hit1, hit2;
  logic               ld1, ld2;

  assign empty     = (cnt_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_inst = empty ? 32'h0 : head[ENT_INST_OFF +: 32];
  assign in_inst   = (BIG_ENDIAN != 0) ? bswap32(bus.if_inst) : bus.if_inst;

  assign bus.if_ready = rst_n && (cnt_q < FULL_CNT);
  assign push         = bus.if_valid && bus.if_ready;

  id_regsel u_regsel (
    .inst  (head_inst),
    .rreg1 (rreg1_raw),
    .rreg2 (rreg2_raw)
  );

  assign rreg1 = rreg1_raw && !empty;
  assign rreg2 = rreg2_raw && !empty;
  assign ra1   = head_inst[25:21];
  assign ra2   = head_inst[20:16];

  // Lowest-index matching source wins; only that source's load flag can stall.
  always_comb begin
    src1 = rd1;
    src2 = rd2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    ld1  = 1'b0;
    ld2  = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (!hit1 && fwd_wreg[i] && (fwd_wa[i*5 +: 5] == ra1)) begin
        hit1 = 1'b1;
        src1 = fwd_wd[i*32 +: 32];
        ld1  = fwd_mreg[i];
      end
      if (!hit2 && fwd_wreg[i] && (fwd_wa[i*5 +: 5] == ra2)) begin
        hit2 = 1'b1;
        src2 = fwd_wd[i*32 +: 32];
        ld2  = fwd_mreg[i];
      end
    end
    if (!rreg1 || (ra1 == 5'd0)) begin
      src1 = 32'h0;
      ld1  = 1'b0;
    end
    if (!rreg2 || (ra2 == 5'd0)) begin
      src2 = 32'h0;
      ld2  = 1'b0;
    end
  end

  assign stall = !empty && (ld1 || ld2);
  assign pop   = !empty && !stall && (!ex_valid_q || bus.ex_ready);

  always_comb begin
    new_entry                         = '0;
    new_entry[ENT_PC_OFF +: 32]       = bus.if_pc;
    new_entry[ENT_INST_OFF +: 32]     = in_inst;
    new_entry[ENT_DLY_OFF]            = bus.if_in_delay;
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    ex_d        = ex_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;

    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      ex_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + AW'(1);
        ex_d.pc       = head[ENT_PC_OFF +: 32];
        ex_d.inst     = head_inst;
        ex_d.src1     = src1;
        ex_d.src2     = src2;
        ex_d.in_delay = head[ENT_DLY_OFF];
        ex_valid_d    = 1'b1;
      end else if (ex_valid_q && bus.ex_ready) begin
        ex_valid_d = 1'b0;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Queue storage carries no reset; occupancy and pointers guard its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= 16'h0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_inst     = ex_q.inst;
  assign bus.ex_src1     = ex_q.src1;
  assign bus.ex_src2     = ex_q.src2;
  assign bus.ex_in_delay = ex_q.in_delay;
  assign occupancy       = cnt_q;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: doc/id_stage_q.md
ID_STAGE_Q -- requirements
Module: id_stage_q

Interface
REQ-001 Parameter DEPTH, default 4, instruction-queue entries; power of two, >=2.
REQ-002 Parameter NFWD, default 2, forwarding sources; index 0 = youngest (execute), highest priority.
REQ-003 Parameter BIG_ENDIAN, default 1, 1 = byte-swap incoming instruction word to little-endian.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 if_valid  in  1  fetch offers an entry; if_ready  out  1  queue accepts.
REQ-007 if_pc  in  32  entry PC; if_inst  in  32  raw instruction; if_in_delay  in  1  delay-slot flag.
REQ-008 flush  in  1  discard all queued and output-register contents.
REQ-009 ra1, ra2  out  5  regfile read addresses (rs, rt of head); rd1, rd2  in  32  regfile read data.
REQ-010 fwd_wreg, fwd_mreg  in  NFWD  per-source write enable, load flag; fwd_wa  in  5*NFWD; fwd_wd  in  32*NFWD.
REQ-011 ex_valid  out  1; ex_ready  in  1; ex_pc, ex_inst, ex_src1, ex_src2  out  32; ex_in_delay  out  1.
REQ-012 occupancy  out  $clog2(DEPTH)+1  queued entries; stall_cnt  out  16  load-use stall cycles.

Function
REQ-013 Push SHALL occur when if_valid && if_ready; if_ready SHALL equal (occupancy < DEPTH); no push when full, even if a pop occurs that cycle.
REQ-014 Stored instruction SHALL be byte-swapped ({[7:0],[15:8],[23:16],[31:24]}) at push when BIG_ENDIAN=1, unmodified otherwise.
REQ-015 Head fields SHALL drive ra1=inst[25:21], ra2=inst[20:16]; rreg1/rreg2 from sub-module id_regsel; ra*/rreg* = 0 when queue empty.
REQ-016 Operand X SHALL resolve: rreg=0 or ra=0 -> 0; else lowest index i with fwd_wreg[i] && fwd_wa[i]==ra -> fwd_wd[i]; else rdX.
REQ-017 Load-use stall SHALL assert when any source i matching under REQ-016 (first match only) has fwd_mreg[i]=1.
REQ-018 Pop SHALL occur when queue non-empty, no stall, and (ex_valid==0 || ex_ready==1); pop loads output register with pc, swapped inst, resolved operands, delay flag and sets ex_valid.
REQ-019 ex_valid && !ex_ready SHALL hold all ex_* outputs stable; ex_valid && ex_ready with no pop SHALL clear ex_valid next cycle.
REQ-020 Latency: entry pushed at edge E SHALL appear on ex_* after edge E+1 when queue was empty and no stall/backpressure.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-022 flush SHALL, at next edge, set occupancy=0, ex_valid=0, pointers=0; flush overrides same-cycle push and pop.
REQ-023 stall_cnt SHALL increment each cycle queue non-empty and REQ-017 stall asserted, saturating at 16'hFFFF; flush does not clear it.

Reset
REQ-024 rst_n=0 at an edge SHALL set occupancy=0, pointers=0, ex_valid=0, all ex_* data=0, stall_cnt=0; if_ready=0 while rst_n=0.
REQ-025 Reset SHALL override flush, push and pop; queue storage need not be cleared.

Structure
REQ-026 Shared package id_pkg SHALL hold opcode/funct constants, queue-entry width (32+32+1) and field offsets.
REQ-027 Sub-module id_regsel (combinational: inst -> rreg1, rreg2) SHALL be the single source of operand-use decode.

Verification
REQ-028 DEPTH=4: push 5 entries back-to-back, ex_ready=0 -> if_ready low after 4th push in queue plus 1 in output reg; occupancy=4.
REQ-029 Push 32'h2402_0834 (BIG_ENDIAN=1) -> ex_inst=32'h3408_0224 two edges after if_valid.
REQ-030 Head addu $3,$1,$2; fwd0 wa=1 wd=32'hAAAA_0000, fwd1 wa=1 wd=32'h5555 -> ex_src1=32'hAAAA_0000; fwd wa=0 -> ex_src1=0.
REQ-031 fwd0 wreg=1 mreg=1 wa=rs of head for 3 cycles -> no pop, ex_valid falls, stall_cnt +3.
REQ-032 Occupancy 3, ex_valid=1, assert flush with if_valid=1 -> next cycle occupancy=0, ex_valid=0, if_ready=1.
REQ-033 rst_n=0 mid-stream with stall_cnt=7 -> after edge all outputs 0, stall_cnt=0.
